// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the RV32M iterative multiply/divide unit.
package ex_muldiv_unit_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;

    function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_muldiv_step.sv
// One iteration of the datapath: mode=0 shift-add multiply, mode=1 restoring divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic              mode,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
        // Remainder after shifting in the next dividend bit; 33 bits so nothing is lost.
        rem_sh = acc_i[2*XLEN-1:XLEN-1];
        ge     = rem_sh >= {1'b0, opnd_i};
        // Result is below the divisor, so the low XLEN bits are exact.
        diff   = rem_sh[XLEN-1:0] - opnd_i;
        acc_o  = acc_i;
        if (mode) begin
            if (ge) acc_o = {diff, acc_i[XLEN-2:0], 1'b1};
            else    acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
        end else begin
            if (acc_i[0]) acc_o = {sum, acc_i[XLEN-1:1]};
            else          acc_o = {1'b0, acc_i[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide engine beside the EX-stage ALU.
// Works on magnitudes for 32 cycles, then applies the sign in one fix-up cycle.
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int STEPS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic [4:0]      dest_addr,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic [4:0]      result_dest
);
    import ex_muldiv_unit_pkg::*;

    localparam int CW = $clog2(STEPS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        dest_q, dest_d;
    logic [4:0]        result_dest_q, result_dest_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step, prod_fix;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [XLEN-1:0]   result_q, result_d, sel;
    logic              neg_q, neg_d;

    logic              accept, is_div, sgn1, sgn2, neg1, neg2, div_zero, ovf;
    logic [XLEN-1:0]   mag1, mag2;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode   (op_q[2]),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        accept   = start & ~flush;
        is_div   = op[2];
        sgn1     = ~(op == OP_MULHU || op == OP_DIVU || op == OP_REMU);
        sgn2     = (op == OP_MUL || op == OP_MULH || op == OP_DIV || op == OP_REM);
        neg1     = sgn1 & data1[XLEN-1];
        neg2     = sgn2 & data2[XLEN-1];
        mag1     = neg_if(neg1, data1);
        mag2     = neg_if(neg2, data2);
        div_zero = is_div & (data2 == '0);
        ovf      = (op == OP_DIV || op == OP_REM) & (data1 == INT_MIN) & (data2 == '1);
    end

    // Sign fix-up and output selection, registered during SIGN.
    always_comb begin
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        case (op_q)
            OP_MUL:                       sel = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: sel = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              sel = neg_if(neg_q, acc_q[XLEN-1:0]);
            default:                      sel = neg_if(neg_q, acc_q[2*XLEN-1:XLEN]);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        op_d          = op_q;
        dest_d        = dest_q;
        result_dest_d = result_dest_q;
        acc_d         = acc_q;
        opnd_d        = opnd_q;
        result_d      = result_q;
        neg_d         = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = op;
                    dest_d = dest_addr;
                    cnt_d  = '0;
                    // Remainder follows the dividend; everything else is sign1^sign2.
                    neg_d  = (is_div & op[1]) ? neg1 : (neg1 ^ neg2);
                    if (div_zero || ovf) begin
                        if (div_zero) result_d = op[1] ? data1 : DIV_ZERO_Q;
                        else          result_d = op[1] ? '0 : INT_MIN;
                        result_dest_d = dest_addr;
                        state_d       = ST_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, is_div ? mag1 : mag2};
                        opnd_d  = is_div ? mag2 : mag1;
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(STEPS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_SIGN;
                end
            end
            ST_SIGN: begin
                result_d      = sel;
                result_dest_d = dest_q;
                state_d       = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            state_d       = ST_IDLE;
            cnt_d         = '0;
            result_d      = result_q;
            result_dest_d = result_dest_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            dest_q        <= '0;
            result_dest_q <= '0;
            acc_q         <= '0;
            opnd_q        <= '0;
            result_q      <= '0;
            neg_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            dest_q        <= dest_d;
            result_dest_q <= result_dest_d;
            acc_q         <= acc_d;
            opnd_q        <= opnd_d;
            result_q      <= result_d;
            neg_q         <= neg_d;
        end
    end

    // The pipeline advances in DONE so EX/MEM captures the result that cycle.
    assign stall        = (state_q == ST_IDLE && accept) || state_q == ST_CALC || state_q == ST_SIGN;
    assign busy         = state_q != ST_IDLE;
    assign result_valid = (state_q == ST_DONE) & ~flush;
    assign result       = result_q;
    assign result_dest  = result_dest_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases plus random ops vs. an arithmetic model.
module tb_ex_muldiv_unit;

    logic        clk, rst, start, flush;
    logic [2:0]  op;
    logic [31:0] data1, data2;
    logic [4:0]  dest_addr;
    logic        stall, busy, result_valid;
    logic [31:0] result;
    logic [4:0]  result_dest;

    int tests = 0;
    int fails = 0;

    ex_muldiv_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .data1        (data1),
        .data2        (data2),
        .dest_addr    (dest_addr),
        .flush        (flush),
        .stall        (stall),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_dest  (result_dest)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, lub;
        logic [63:0] ua, ub, p;
        logic        dz, ov;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        lub = longint'(ub);
        dz  = (b == 32'd0);
        ov  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sa * sb;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * lub; return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (dz) return 32'hFFFF_FFFF;
                if (ov) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return dz ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (dz) return a;
                if (ov) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return dz ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 32'd0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    // Drives one instruction held like a stalled EX stage; returns what was observed.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output int stall_bad);
        op = o; data1 = a; data2 = b; dest_addr = rd; start = 1'b1;
        lat = -1; stall_bad = 0; res = '0; rdo = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = c; res = result; rdo = result_dest;
                if (stall) stall_bad++;
                break;
            end
            if (!stall) stall_bad++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++; if (stall !== 1'b0)        begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
        tests++; if (busy !== 1'b0)         begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", result_valid); end
        tests++; if (result !== 32'd0)      begin fails++; $display("FAIL reset_result got=%h exp=0", result); end
        tests++; if (result_dest !== 5'd0)  begin fails++; $display("FAIL reset_dest got=%0d exp=0", result_dest); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [2:0]  vo[12];
        logic [31:0] va[12], vb[12], ve[12];
        int          vl[12];
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, sb;
        vo[0]=3'd0;  va[0]=32'h7;          vb[0]=32'hFFFFFFFD;  ve[0]=32'hFFFFFFEB;  vl[0]=34;
        vo[1]=3'd3;  va[1]=32'hFFFFFFFF;   vb[1]=32'hFFFFFFFF;  ve[1]=32'hFFFFFFFE;  vl[1]=34;
        vo[2]=3'd1;  va[2]=32'hFFFFFFFF;   vb[2]=32'hFFFFFFFF;  ve[2]=32'h0;         vl[2]=34;
        vo[3]=3'd2;  va[3]=32'hFFFFFFFF;   vb[3]=32'h2;         ve[3]=32'hFFFFFFFF;  vl[3]=34;
        vo[4]=3'd4;  va[4]=32'hFFFFFFF9;   vb[4]=32'h2;         ve[4]=32'hFFFFFFFD;  vl[4]=34;
        vo[5]=3'd6;  va[5]=32'hFFFFFFF9;   vb[5]=32'h2;         ve[5]=32'hFFFFFFFF;  vl[5]=34;
        vo[6]=3'd5;  va[6]=32'd100;        vb[6]=32'd7;         ve[6]=32'd14;        vl[6]=34;
        vo[7]=3'd7;  va[7]=32'd100;        vb[7]=32'd7;         ve[7]=32'd2;         vl[7]=34;
        vo[8]=3'd5;  va[8]=32'd5;          vb[8]=32'd0;         ve[8]=32'hFFFFFFFF;  vl[8]=1;
        vo[9]=3'd6;  va[9]=32'd5;          vb[9]=32'd0;         ve[9]=32'd5;         vl[9]=1;
        vo[10]=3'd4; va[10]=32'h80000000;  vb[10]=32'hFFFFFFFF; ve[10]=32'h80000000; vl[10]=1;
        vo[11]=3'd6; va[11]=32'h80000000;  vb[11]=32'hFFFFFFFF; ve[11]=32'h0;        vl[11]=1;
        for (int i = 0; i < 12; i++) begin
            do_op(vo[i], va[i], vb[i], 5'(i + 1), res, rdo, lat, sb);
            tests++; if (res !== ve[i]) begin fails++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, ve[i]); end
            tests++; if (lat != vl[i]) begin fails++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, vl[i]); end
            tests++; if (sb != 0) begin fails++; $display("FAIL dir%0d_stall bad_cycles=%0d exp=0", i, sb); end
            tests++; if (rdo !== 5'(i + 1)) begin fails++; $display("FAIL dir%0d_dest got=%0d exp=%0d", i, rdo, i + 1); end
            // start was still high through DONE: no second pulse may follow.
            @(negedge clk);
            tests++; if (result_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_single_pulse got=%b exp=0", i, result_valid); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, res, exp;
        logic [4:0]  rd, rdo;
        int          lat, sb;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'($urandom_range(0, 300));
                default: a = $urandom;
            endcase
            rd  = 5'($urandom_range(0, 31));
            exp = model(o, a, b);
            do_op(o, a, b, rd, res, rdo, lat, sb);
            tests++; if (res !== exp) begin fails++; $display("FAIL rand%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, exp); end
            tests++; if (lat != model_lat(o, a, b)) begin fails++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, model_lat(o, a, b)); end
            tests++; if (rdo !== rd || sb != 0) begin fails++; $display("FAIL rand%0d_dest_stall dest=%0d exp=%0d stallbad=%0d", i, rdo, rd, sb); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat, sb;
        do_op(3'd5, 32'd9, 32'd0, 5'd3, res, rdo, lat, sb);
        tests++; if (res !== 32'hFFFF_FFFF || lat != 1) begin fails++; $display("FAIL b2b_fast got=%h lat=%0d exp=ffffffff lat=1", res, lat); end
        do_op(3'd7, 32'd9, 32'd0, 5'd4, res, rdo, lat, sb);
        tests++; if (res !== 32'd9 || lat != 1) begin fails++; $display("FAIL b2b_fast2 got=%h lat=%0d exp=9 lat=1", res, lat); end
        do_op(3'd0, 32'd1000, 32'd1000, 5'd6, res, rdo, lat, sb);
        tests++; if (res !== 32'd1000000 || lat != 34) begin fails++; $display("FAIL b2b_mul got=%h lat=%0d exp=%h lat=34", res, lat, 32'd1000000); end
        do_op(3'd5, 32'd1000, 32'd3, 5'd7, res, rdo, lat, sb);
        tests++; if (res !== 32'd333 || lat != 34) begin fails++; $display("FAIL b2b_divu got=%0d lat=%0d exp=333 lat=34", res, lat); end
    endtask

    task automatic test_flush();
        logic [31:0] prev, res;
        logic [4:0]  prevd, rdo;
        int          pulses, lat, sb;
        prev = result; prevd = result_dest;
        op = 3'd4; data1 = 32'd1000; data2 = 32'd7; dest_addr = 5'd20; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL flush_idle busy=%b stall=%b exp=0,0", busy, stall); end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid || stall || busy) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL flush_no_result active_cycles=%0d exp=0", pulses); end
        tests++; if (result !== prev || result_dest !== prevd) begin fails++; $display("FAIL flush_hold result=%h dest=%0d exp=%h,%0d", result, result_dest, prev, prevd); end
        @(posedge clk); #1;
        op = 3'd0; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL flush_start_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL flush_start_accept busy=%b exp=0", busy); end
        @(posedge clk); #1;
        do_op(3'd0, 32'd3, 32'd4, 5'd5, res, rdo, lat, sb);
        tests++; if (res !== 32'd12 || lat != 34 || rdo !== 5'd5) begin fails++; $display("FAIL flush_then_mul got=%0d lat=%0d dest=%0d exp=12 lat=34 dest=5", res, lat, rdo); end
    endtask

    task automatic test_reset_mid();
        int pulses;
        op = 3'd0; data1 = 32'd5; data2 = 32'd6; dest_addr = 5'd9; start = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        tests++; if (result !== 32'd0 || result_dest !== 5'd0) begin fails++; $display("FAIL rstmid_result result=%h dest=%0d exp=0,0", result, result_dest); end
        tests++; if (busy !== 1'b0 || stall !== 1'b0 || result_valid !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl busy=%b stall=%b valid=%b exp=0", busy, stall, result_valid); end
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL rstmid_no_result pulses=%0d exp=0", pulses); end
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; start = 1'b0; flush = 1'b0;
        op = '0; data1 = '0; data2 = '0; dest_addr = '0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine beside the EX-stage ALU.
- Takes operands and op from the EX stage and runs a 32-step shift-add or restoring-divide sequence.
- Drives a stall to the hazard unit and presents one result for the EX/MEM register.
- Handles the RISC-V divide-by-zero and overflow corner cases on a 1-cycle fast path.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
STEPS, 32, iteration count; must equal XLEN.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  EX stage holds an M-extension instruction
op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
data1  in  32  rs1 value (forwarded)
data2  in  32  rs2 value (forwarded)
dest_addr  in  5  rd of the instruction
flush  in  1  kill the in-flight operation (branch/jump taken)
stall  out  1  freeze PC, IF/ID and ID/EX
busy  out  1  state != IDLE
result  out  32  final value; valid only with result_valid
result_valid  out  1  one-cycle pulse
result_dest  out  5  rd latched at accept

Behaviour:
- Reset:
  - state=IDLE, counter=0.
  - result=0, result_valid=0, result_dest=0, busy=0.
  - stall=0 in the cycle after reset deasserts.
- States: IDLE, CALC, SIGN, DONE.
- IDLE:
  - Accept when start=1 and flush=0.
  - On accept, latch op and dest_addr.
  - Latch operand magnitudes: a signed operand is negated if negative.
    - MUL/MULH/DIV/REM: both operands signed.
    - MULHSU: only data1 signed.
    - MULHU/DIVU/REMU: unsigned.
  - Latch the result sign.
    - Multiply: sign = sign1 XOR sign2, using signedness as above.
    - Quotient: sign1 XOR sign2.
    - Remainder: sign of dividend.
- Fast path (IDLE→DONE directly):
  - Divide by zero (data2=0, op[2]=1): quotient=0xFFFFFFFF; remainder=data1.
  - Signed overflow (DIV/REM, data1=0x80000000, data2=0xFFFFFFFF): quotient=0x80000000; remainder=0.
- Otherwise IDLE→CALC with counter=0.
- CALC, one bit per cycle; counter increments and leaves for SIGN after counter=31 (32 cycles).
  - Multiply: 64-bit product register; add the multiplicand if the LSB is set, then shift right.
  - Divide: restoring. Shift the {rem,quot} left; subtract the divisor if rem>=divisor and set the quotient bit.
- SIGN:
  - Conditionally 2's-complement the 64-bit product or the quotient/remainder.
  - Select output: MUL low 32 bits; MULH* high 32 bits; DIV* quotient; REM* remainder.
  - Register the selection into result.
- DONE:
  - result_valid=1 for exactly this cycle, then →IDLE.
  - start seen in DONE is ignored; it is the same stalled instruction.
- Latency (accept edge = cycle 0):
  - Normal: CALC cycles 1–32, SIGN 33, result_valid in cycle 34.
  - Fast path: result_valid in cycle 1.
- stall (combinational) = (state==IDLE & start & ~flush) | state==CALC | state==SIGN | (state==DONE is 0).
  - The pipeline advances in the DONE cycle, so EX/MEM captures the result.
- busy = state != IDLE.
- result holds its value after DONE until the next SIGN or fast-path load; result_valid alone qualifies it.
- Flush:
  - In any state, the next state is IDLE, counter=0, result_valid=0.
  - No result is produced; result and result_dest are unchanged.
  - flush with start in IDLE is not an accept.
- Simultaneous events:
  - rst has priority over flush; flush has priority over completion.
  - Reset mid-CALC discards everything.
- Back-to-back: a new start is accepted in the IDLE cycle directly after DONE. There is no dead cycle beyond DONE.
- Arithmetic: all magnitudes and intermediates are unsigned. Widths are 33-bit for the divide subtract and 64-bit for the product. There is no wrap except the defined 0x80000000 negation.

Decomposition:
- Shared encodings package:
  - M-op funct3 constants (MUL…REMU).
  - State encodings (2-bit IDLE/CALC/SIGN/DONE).
  - DIV_ZERO_Q=0xFFFFFFFF and INT_MIN=0x80000000.
- One sub-module, muldiv_step: combinational single iteration (mul add-shift or div compare-subtract-shift) selected by a mode bit.
- The FSM, counter and sign fix-up stay in ex_muldiv_unit.

Test Plan:
1. MUL data1=0x00000007, data2=0xFFFFFFFD (−3) → result_valid at cycle 34, result=0xFFFFFFEB, stall high cycles 0–33, low at 34.
2. MULHU 0xFFFFFFFF×0xFFFFFFFF → result=0xFFFFFFFE; MULH of the same operands → 0x00000000; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
3. DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100/7 → 14 and REMU 100/7 → 2, each at cycle 34.
4. DIVU 5/0 → 0xFFFFFFFF at cycle 1; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM of the same → 0, both at cycle 1.
5. Start DIV, assert flush in cycle 10 → IDLE next cycle, no result_valid ever, stall low; a new MUL 3×4 is accepted right after → 12 at +34.
6. rst asserted in cycle 20 of a MUL → all outputs 0 next cycle; start held high in DONE → exactly one result_valid pulse.
